lsu: RTL and testbench

- Load/store unit directly downstream of the control decoder.
- Consumes the decoder's `mem_read` / `mem_write` enums plus the ALU address and rs2 data, and runs a multi-cycle valid/grant transaction on the data-memory bus.
- Returns aligned, sign/zero-extended load data to the register writeback mux.
- Raises `stall` so the core holds PC and register file until the access completes.

---
 rtl/lsu.sv | 266 ++++++++++++++++++++++++++
 tb/tb_lsu.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// Load/store unit: turns decoder memory ops into a valid/grant data-bus
// transaction and returns aligned, sign/zero-extended load data to writeback.

package lsu_pkg;
    typedef enum logic [2:0] {
        MEM_READ_NONE  = 3'd0,
        MEM_READ_BYTE  = 3'd1,
        MEM_READ_HALF  = 3'd2,
        MEM_READ_WORD  = 3'd3,
        MEM_READ_BYTEU = 3'd4,
        MEM_READ_HALFU = 3'd5
    } mem_read_t;

    typedef enum logic [1:0] {
        MEM_WRITE_NONE = 2'd0,
        MEM_WRITE_BYTE = 2'd1,
        MEM_WRITE_HALF = 2'd2,
        MEM_WRITE_WORD = 2'd3
    } mem_write_t;
endpackage

module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  mem_read_t   mem_read,
    input  mem_write_t  mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        misaligned,
    output logic        bus_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    // One spare count above TIMEOUT_CYCLES-1 so a grant on the last cycle
    // can still be followed by a single WAIT cycle without wrapping.
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [31:0]       bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [31:0]       bus_wdata_q, bus_wdata_d;
    mem_read_t         rd_op_q, rd_op_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              done_q, done_d;
    logic              misaligned_q, misaligned_d;
    logic              bus_err_q, bus_err_d;

    logic              is_write;
    logic              is_read;
    logic              active;
    logic              aligned;
    size_e             acc_size;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;

    function automatic logic [31:0] extract(input mem_read_t op,
                                            input logic [1:0] off,
                                            input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(d >> {off, 3'b000});
        h = 16'(d >> {off[1], 4'b0000});
        case (op)
            MEM_READ_BYTE:  extract = {{24{b[7]}}, b};
            MEM_READ_BYTEU: extract = {24'd0, b};
            MEM_READ_HALF:  extract = {{16{h[15]}}, h};
            MEM_READ_HALFU: extract = {16'd0, h};
            default:        extract = d;
        endcase
    endfunction

    // Decode of the incoming op: size, alignment and store lane placement.
    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        is_write  = (mem_write != MEM_WRITE_NONE);
        is_read   = (mem_read != MEM_READ_NONE);
        active    = req_valid && (is_write || is_read);
        acc_size  = SZ_WORD;
        be_new    = 4'b1111;
        wdata_new = wdata;

        if (is_write) begin
            case (mem_write)
                MEM_WRITE_BYTE: acc_size = SZ_BYTE;
                MEM_WRITE_HALF: acc_size = SZ_HALF;
                default:        acc_size = SZ_WORD;
            endcase
        end else begin
            case (mem_read)
                MEM_READ_BYTE, MEM_READ_BYTEU: acc_size = SZ_BYTE;
                MEM_READ_HALF, MEM_READ_HALFU: acc_size = SZ_HALF;
                default:                       acc_size = SZ_WORD;
            endcase
        end

        case (acc_size)
            SZ_BYTE: aligned = 1'b1;
            SZ_HALF: aligned = ~addr[0];
            default: aligned = (addr[1:0] == 2'b00);
        endcase

        if (is_write) begin
            case (acc_size)
                SZ_BYTE: begin
                    be_new    = 4'b0001 << addr[1:0];
                    wdata_new = {4{wdata[7:0]}};
                end
                SZ_HALF: begin
                    be_new    = addr[1] ? 4'b1100 : 4'b0011;
                    wdata_new = {2{wdata[15:0]}};
                end
                default: begin
                    be_new    = 4'b1111;
                    wdata_new = wdata;
                end
            endcase
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_be_d     = bus_be_q;
        bus_wdata_d  = bus_wdata_q;
        rd_op_d      = rd_op_q;
        off_d        = off_q;
        rdata_d      = rdata_q;
        done_d       = 1'b0;
        misaligned_d = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (active && aligned) begin
                    state_d     = S_REQ;
                    cnt_d       = '0;
                    bus_req_d   = 1'b1;
                    bus_we_d    = is_write;
                    bus_addr_d  = {addr[31:2], 2'b00};
                    bus_be_d    = be_new;
                    bus_wdata_d = wdata_new;
                    rd_op_d     = is_write ? MEM_READ_NONE : mem_read;
                    off_d       = addr[1:0];
                end else if (active) begin
                    state_d      = S_DONE;
                    done_d       = 1'b1;
                    misaligned_d = 1'b1;
                end
            end
            S_REQ: begin
                if (bus_gnt) begin
                    cnt_d     = cnt_q + 1'b1;
                    bus_req_d = 1'b0;
                    if (bus_we_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    bus_req_d = 1'b0;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (bus_rvalid) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    rdata_d = extract(rd_op_q, off_q, bus_rdata);
                end else if (cnt_q >= CNT_LAST) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // The core advances during this cycle, so req_valid is stale.
                state_d = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_be_q     <= '0;
            bus_wdata_q  <= '0;
            rd_op_q      <= MEM_READ_NONE;
            off_q        <= '0;
            rdata_q      <= '0;
            done_q       <= 1'b0;
            misaligned_q <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_be_q     <= bus_be_d;
            bus_wdata_q  <= bus_wdata_d;
            rd_op_q      <= rd_op_d;
            off_q        <= off_d;
            rdata_q      <= rdata_d;
            done_q       <= done_d;
            misaligned_q <= misaligned_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign stall      = ((state_q == S_IDLE) && active) ||
                        (state_q == S_REQ) || (state_q == S_WAIT);
    assign done       = done_q;
    assign rdata      = rdata_q;
    assign misaligned = misaligned_q;
    assign bus_err    = bus_err_q;
    assign bus_req    = bus_req_q;
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: a scoreboard of expected completions plus per-scenario
// checks of bus lanes, latency and the timeout path on a short-timeout copy.

module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    mem_read_t   mem_read = MEM_READ_NONE;
    mem_write_t  mem_write = MEM_WRITE_NONE;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = '0;

    logic        stall, done, misaligned, bus_err, bus_req, bus_we;
    logic [31:0] rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    logic        req_valid_to = 1'b0;
    logic        bus_gnt_to = 1'b0;
    logic        bus_rvalid_to = 1'b0;
    logic        stall_to, done_to, misaligned_to, bus_err_to, bus_req_to, bus_we_to;
    logic [31:0] rdata_to, bus_addr_to, bus_wdata_to;
    logic [3:0]  bus_be_to;

    always #5 clk = ~clk;

    lsu dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .rdata(rdata), .misaligned(misaligned), .bus_err(bus_err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata)
    );

    lsu #(.TIMEOUT_CYCLES(4)) dut_to (
        .clk(clk), .rst(rst), .req_valid(req_valid_to), .mem_read(mem_read),
        .mem_write(mem_write), .addr(addr), .wdata(wdata), .stall(stall_to),
        .done(done_to), .rdata(rdata_to), .misaligned(misaligned_to),
        .bus_err(bus_err_to), .bus_req(bus_req_to), .bus_we(bus_we_to),
        .bus_addr(bus_addr_to), .bus_be(bus_be_to), .bus_wdata(bus_wdata_to),
        .bus_gnt(bus_gnt_to), .bus_rvalid(bus_rvalid_to), .bus_rdata(bus_rdata)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        err;
    } exp_t;

    typedef struct {
        int          stall_cyc;
        int          req_cyc;
        int          done_cyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
        logic        stable;
    } obs_t;

    typedef struct {
        mem_read_t   rd;
        mem_write_t  wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic [3:0]  x_be;
    } st_vec_t;

    typedef struct {
        mem_read_t   rd;
        logic [31:0] a;
        logic [31:0] rbus;
        int          gw;
        int          rw;
        logic [31:0] x_rdata;
    } ld_vec_t;

    exp_t        sb_q[$];
    exp_t        sb_e;
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_rdata = '0;
    st_vec_t     st_v[6];
    ld_vec_t     ld_v[10];

    // Scoreboard side: every completion of the main DUT is matched in order.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_done: done=1 observed, required no completion");
            end else begin
                sb_e = sb_q.pop_front();
                total++;
                if (rdata !== sb_e.rdata) begin
                    bad++;
                    $display("FAIL sb_rdata: got %h expected %h", rdata, sb_e.rdata);
                end
                total++;
                if (misaligned !== sb_e.mis) begin
                    bad++;
                    $display("FAIL sb_misaligned: got %b expected %b", misaligned, sb_e.mis);
                end
                total++;
                if (bus_err !== sb_e.err) begin
                    bad++;
                    $display("FAIL sb_bus_err: got %b expected %b", bus_err, sb_e.err);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drives one access on the main DUT and plays the memory side with the
    // requested grant and response delays, recording what the bus showed.
    task automatic run_access(input mem_read_t rd, input mem_write_t wr,
                              input logic [31:0] a, input logic [31:0] wd,
                              input int gnt_wait, input int rv_wait,
                              input logic [31:0] rbus, output obs_t o);
        int   wait_cyc;
        logic granted;
        o.stall_cyc = 0;
        o.req_cyc   = 0;
        o.done_cyc  = -1;
        o.addr      = '0;
        o.wdata     = '0;
        o.be        = '0;
        o.we        = 1'b0;
        o.stable    = 1'b1;
        wait_cyc    = 0;
        granted     = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
        bus_rdata = rbus;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (stall === 1'b1) o.stall_cyc++;
            if (bus_req === 1'b1) begin
                if (o.req_cyc == 0) begin
                    o.addr  = bus_addr;
                    o.wdata = bus_wdata;
                    o.be    = bus_be;
                    o.we    = bus_we;
                end else if ({bus_addr, bus_wdata, bus_be, bus_we} !== {o.addr, o.wdata, o.be, o.we}) begin
                    o.stable = 1'b0;
                end
                o.req_cyc++;
            end
            if (done === 1'b1) begin
                o.done_cyc = cyc;
                bus_gnt    = 1'b0;
                bus_rvalid = 1'b0;
                break;
            end
            if (granted) wait_cyc++;
            bus_rvalid = granted && (wait_cyc > rv_wait);
            bus_gnt    = (bus_req === 1'b1) && (o.req_cyc > gnt_wait);
            if (bus_gnt) granted = 1'b1;
        end
        @(posedge clk); #1;
        req_valid  = 1'b0;
        mem_read   = MEM_READ_NONE;
        mem_write  = MEM_WRITE_NONE;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++;
        if ({stall, done, misaligned, bus_err, bus_req, bus_we, bus_be} !== 10'd0) begin
            bad++;
            $display("FAIL reset_ctrl: got %b expected 0", {stall, done, misaligned, bus_err, bus_req, bus_we, bus_be});
        end
        total++;
        if ({bus_addr, bus_wdata, rdata} !== 96'd0) begin
            bad++;
            $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h expected all 0", bus_addr, bus_wdata, rdata);
        end
        total++;
        if ({stall_to, done_to, bus_req_to, rdata_to} !== 35'd0) begin
            bad++;
            $display("FAIL reset_to: got stall=%b done=%b req=%b rdata=%h expected 0", stall_to, done_to, bus_req_to, rdata_to);
        end
    endtask

    task automatic test_no_access();
        logic quiet;
        quiet = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b1;
        mem_read  = MEM_READ_NONE;
        mem_write = MEM_WRITE_NONE;
        repeat (3) begin
            @(negedge clk);
            if (stall !== 1'b0 || bus_req !== 1'b0) quiet = 1'b0;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_read  = MEM_READ_WORD;
        repeat (2) begin
            @(negedge clk);
            if (stall !== 1'b0 || bus_req !== 1'b0) quiet = 1'b0;
        end
        @(posedge clk); #1;
        mem_read = MEM_READ_NONE;
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL no_access: stall/bus_req went high, required both 0");
        end
    endtask

    task automatic test_store();
        obs_t o;
        int   gw;
        st_v[0] = '{MEM_READ_NONE, MEM_WRITE_WORD, 32'h0000_0144, 32'hDEAD_BEEF, 32'h0000_0144, 32'hDEAD_BEEF, 4'b1111};
        st_v[1] = '{MEM_READ_NONE, MEM_WRITE_BYTE, 32'h0000_0103, 32'h0000_00A5, 32'h0000_0100, 32'hA5A5_A5A5, 4'b1000};
        st_v[2] = '{MEM_READ_NONE, MEM_WRITE_BYTE, 32'h0000_0101, 32'h1234_5677, 32'h0000_0100, 32'h7777_7777, 4'b0010};
        st_v[3] = '{MEM_READ_NONE, MEM_WRITE_HALF, 32'h0000_0102, 32'hCAFE_1234, 32'h0000_0100, 32'h1234_1234, 4'b1100};
        st_v[4] = '{MEM_READ_NONE, MEM_WRITE_HALF, 32'h8000_03FC, 32'h0000_BEEF, 32'h8000_03FC, 32'hBEEF_BEEF, 4'b0011};
        st_v[5] = '{MEM_READ_WORD, MEM_WRITE_BYTE, 32'h0000_02F1, 32'h0000_005A, 32'h0000_02F0, 32'h5A5A_5A5A, 4'b0010};
        for (int i = 0; i < 6; i++) begin
            gw = i % 2;
            sb_q.push_back('{exp_rdata, 1'b0, 1'b0});
            run_access(st_v[i].rd, st_v[i].wr, st_v[i].a, st_v[i].wd, gw, 0, 32'h0, o);
            total++;
            if (o.done_cyc != 2 + gw || o.stall_cyc != 2 + gw || o.req_cyc != 1 + gw) begin
                bad++;
                $display("FAIL store_timing[%0d]: got done@%0d stall=%0d req=%0d expected %0d/%0d/%0d",
                         i, o.done_cyc, o.stall_cyc, o.req_cyc, 2 + gw, 2 + gw, 1 + gw);
            end
            total++;
            if (o.addr !== st_v[i].x_addr || o.wdata !== st_v[i].x_wdata || o.be !== st_v[i].x_be || o.we !== 1'b1) begin
                bad++;
                $display("FAIL store_bus[%0d]: got addr=%h wdata=%h be=%b we=%b expected %h %h %b 1",
                         i, o.addr, o.wdata, o.be, o.we, st_v[i].x_addr, st_v[i].x_wdata, st_v[i].x_be);
            end
            total++;
            if (o.stable !== 1'b1) begin
                bad++;
                $display("FAIL store_stable[%0d]: bus outputs changed while bus_req held, required stable", i);
            end
        end
    endtask

    task automatic test_load();
        obs_t o;
        ld_vec_t v;
        ld_v[0] = '{MEM_READ_BYTE,  32'h0000_0202, 32'h12F0_3456, 2, 2, 32'hFFFF_FFF0};
        ld_v[1] = '{MEM_READ_BYTEU, 32'h0000_0202, 32'h12F0_3456, 2, 2, 32'h0000_00F0};
        ld_v[2] = '{MEM_READ_HALF,  32'h0000_0202, 32'h12F0_3456, 0, 0, 32'h0000_12F0};
        ld_v[3] = '{MEM_READ_HALFU, 32'h0000_0200, 32'h12F0_3456, 1, 0, 32'h0000_3456};
        ld_v[4] = '{MEM_READ_HALF,  32'h0000_0200, 32'h0000_8001, 0, 1, 32'hFFFF_8001};
        ld_v[5] = '{MEM_READ_BYTE,  32'h0000_0201, 32'h12F0_3456, 0, 0, 32'h0000_0034};
        ld_v[6] = '{MEM_READ_BYTEU, 32'h0000_0203, 32'h8000_0000, 0, 0, 32'h0000_0080};
        ld_v[7] = '{MEM_READ_WORD,  32'h0000_1000, 32'hCAFE_BABE, 0, 3, 32'hCAFE_BABE};
        ld_v[8] = '{MEM_READ_HALFU, 32'h0000_0202, 32'hABCD_0000, 0, 0, 32'h0000_ABCD};
        ld_v[9] = '{MEM_READ_BYTE,  32'h0000_0200, 32'h0000_00FF, 1, 1, 32'hFFFF_FFFF};
        for (int i = 0; i < 10; i++) begin
            v = ld_v[i];
            sb_q.push_back('{v.x_rdata, 1'b0, 1'b0});
            exp_rdata = v.x_rdata;
            run_access(v.rd, MEM_WRITE_NONE, v.a, 32'h5555_AAAA, v.gw, v.rw, v.rbus, o);
            total++;
            if (o.done_cyc != 3 + v.gw + v.rw || o.stall_cyc != 3 + v.gw + v.rw || o.req_cyc != 1 + v.gw) begin
                bad++;
                $display("FAIL load_timing[%0d]: got done@%0d stall=%0d req=%0d expected %0d/%0d/%0d",
                         i, o.done_cyc, o.stall_cyc, o.req_cyc, 3 + v.gw + v.rw, 3 + v.gw + v.rw, 1 + v.gw);
            end
            total++;
            if (o.addr !== {v.a[31:2], 2'b00} || o.be !== 4'b1111 || o.we !== 1'b0 || o.stable !== 1'b1) begin
                bad++;
                $display("FAIL load_bus[%0d]: got addr=%h be=%b we=%b stable=%b expected %h 1111 0 1",
                         i, o.addr, o.be, o.we, o.stable, {v.a[31:2], 2'b00});
            end
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        mem_read_t   rds[5] = '{MEM_READ_HALF,  MEM_READ_NONE,  MEM_READ_WORD,  MEM_READ_HALFU, MEM_READ_NONE};
        mem_write_t  wrs[5] = '{MEM_WRITE_NONE, MEM_WRITE_WORD, MEM_WRITE_NONE, MEM_WRITE_NONE, MEM_WRITE_HALF};
        logic [31:0] as[5]  = '{32'h0000_0201,  32'h0000_0102,  32'h0000_0203,  32'h0000_0203,  32'h0000_01FF};
        for (int i = 0; i < 5; i++) begin
            sb_q.push_back('{exp_rdata, 1'b1, 1'b0});
            run_access(rds[i], wrs[i], as[i], 32'h1111_2222, 0, 0, 32'h9999_9999, o);
            total++;
            if (o.done_cyc != 1 || o.stall_cyc != 1 || o.req_cyc != 0) begin
                bad++;
                $display("FAIL misaligned[%0d]: got done@%0d stall=%0d req=%0d expected 1/1/0",
                         i, o.done_cyc, o.stall_cyc, o.req_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        sb_q.push_back('{32'h0BAD_F00D, 1'b0, 1'b0});
        exp_rdata = 32'h0BAD_F00D;
        run_access(MEM_READ_WORD, MEM_WRITE_NONE, 32'h0000_0040, 32'h0, 0, 0, 32'h0BAD_F00D, o);
        @(negedge clk);
        total++;
        if (done !== 1'b0 || bus_req !== 1'b0 || stall !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: got done=%b bus_req=%b stall=%b after completion, expected 0 0 0", done, bus_req, stall);
        end
        sb_q.push_back('{exp_rdata, 1'b0, 1'b0});
        run_access(MEM_READ_NONE, MEM_WRITE_WORD, 32'h0000_0044, 32'h7654_3210, 0, 0, 32'h0, o);
        total++;
        if (o.done_cyc != 2 || o.wdata !== 32'h7654_3210 || o.addr !== 32'h0000_0044) begin
            bad++;
            $display("FAIL b2b_store: got done@%0d wdata=%h addr=%h expected 2 76543210 00000044", o.done_cyc, o.wdata, o.addr);
        end
        sb_q.push_back('{32'h0000_0081, 1'b0, 1'b0});
        exp_rdata = 32'h0000_0081;
        run_access(MEM_READ_BYTEU, MEM_WRITE_NONE, 32'h0000_0047, 32'h0, 0, 0, 32'h8100_0000, o);
        total++;
        if (o.done_cyc != 3) begin
            bad++;
            $display("FAIL b2b_load: got done@%0d expected 3", o.done_cyc);
        end
    endtask

    task automatic test_reset_in_wait();
        logic quiet;
        @(posedge clk); #1;
        req_valid = 1'b1;
        mem_read  = MEM_READ_WORD;
        mem_write = MEM_WRITE_NONE;
        addr      = 32'h0000_0080;
        bus_rdata = 32'h1357_9BDF;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus_req !== 1'b1) begin
            bad++;
            $display("FAIL rst_wait_req: got bus_req=%b expected 1", bus_req);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        bus_gnt = 1'b0;
        total++;
        if (bus_req !== 1'b0 || stall !== 1'b1) begin
            bad++;
            $display("FAIL rst_wait_state: got bus_req=%b stall=%b expected 0 1", bus_req, stall);
        end
        rst       = 1'b1;
        req_valid = 1'b0;
        mem_read  = MEM_READ_NONE;
        @(negedge clk);
        total++;
        if (bus_req !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL rst_wait_after: got bus_req=%b stall=%b done=%b expected 0 0 0", bus_req, stall, done);
        end
        rst        = 1'b0;
        bus_rvalid = 1'b1;
        exp_rdata  = 32'h0;
        quiet      = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus_rvalid = 1'b0;
            if (done !== 1'b0 || stall !== 1'b0 || rdata !== 32'h0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL rst_wait_rvalid: late rvalid changed done/stall/rdata (rdata=%h), required ignored", rdata);
        end
    endtask

    task automatic test_timeout();
        int   req_cnt;
        int   done_at;
        logic quiet;
        @(posedge clk); #1;
        req_valid_to = 1'b1;
        mem_read     = MEM_READ_WORD;
        mem_write    = MEM_WRITE_NONE;
        addr         = 32'h0000_0300;
        bus_rdata    = 32'h12F0_3456;
        @(negedge clk);
        @(negedge clk);
        bus_gnt_to = 1'b1;
        @(negedge clk);
        bus_gnt_to    = 1'b0;
        bus_rvalid_to = 1'b1;
        @(negedge clk);
        bus_rvalid_to = 1'b0;
        total++;
        if (done_to !== 1'b1 || rdata_to !== 32'h12F0_3456 || bus_err_to !== 1'b0) begin
            bad++;
            $display("FAIL to_prime: got done=%b rdata=%h err=%b expected 1 12f03456 0", done_to, rdata_to, bus_err_to);
        end
        @(posedge clk); #1;
        req_valid_to = 1'b0;
        @(posedge clk); #1;
        req_valid_to = 1'b1;
        addr         = 32'h0000_0304;
        req_cnt      = 0;
        done_at      = -1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (bus_req_to === 1'b1) req_cnt++;
            if (done_to === 1'b1) begin
                done_at = cyc;
                break;
            end
        end
        total++;
        if (done_at != 5 || req_cnt != 4) begin
            bad++;
            $display("FAIL to_timing: got done@%0d req_cycles=%0d expected 5 4", done_at, req_cnt);
        end
        total++;
        if (bus_err_to !== 1'b1 || rdata_to !== 32'h0 || bus_req_to !== 1'b0 || misaligned_to !== 1'b0) begin
            bad++;
            $display("FAIL to_outputs: got err=%b rdata=%h req=%b mis=%b expected 1 00000000 0 0",
                     bus_err_to, rdata_to, bus_req_to, misaligned_to);
        end
        @(posedge clk); #1;
        req_valid_to  = 1'b0;
        mem_read      = MEM_READ_NONE;
        bus_rvalid_to = 1'b1;
        quiet         = 1'b1;
        repeat (3) begin
            @(negedge clk);
            bus_rvalid_to = 1'b0;
            if (done_to !== 1'b0 || bus_req_to !== 1'b0 || bus_err_to !== 1'b0 ||
                stall_to !== 1'b0 || rdata_to !== 32'h0) quiet = 1'b0;
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL to_late_rvalid: late rvalid disturbed outputs (rdata=%h), required ignored", rdata_to);
        end
    endtask

    initial begin
        test_reset();
        test_no_access();
        test_store();
        test_load();
        test_misaligned();
        test_back_to_back();
        test_reset_in_wait();
        test_timeout();
        repeat (2) @(negedge clk);
        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending completions expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
